fifo_serializer_tx: RTL and testbench

Downstream consumer of the chip's data FIFO. It pops one FIFO word at a time and shifts it off chip as a framed, LSB-first serial stream on a single pad. Parity is not stored in the FIFO, so this block regenerates the word's odd parity at transmit time. It sits between the FIFO's read port and the digital output pad.

---
 rtl/fifo_serializer_tx_if.sv | 17 +
 rtl/fifo_serializer_tx.sv | 147 ++++++++++++++
 tb/tb_fifo_serializer_tx.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_serializer_tx_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : fifo_serializer_tx_if                                      |
// | Purpose  : Show-ahead FIFO read port (head word, empty flag, pop).    |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
interface fifo_serializer_tx_if #(
  parameter int FIFO_WIDTH = 64
);
  logic [FIFO_WIDTH-1:0] data_in;
  logic                  fifo_empty;
  logic                  read_n;

  modport master (output data_in, output fifo_empty, input read_n);
  modport slave  (input data_in, input fifo_empty, output read_n);
endinterface
`default_nettype wire

// File: rtl/fifo_serializer_tx.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : fifo_serializer_tx                                         |
// | Purpose  : Pops FIFO words and sends framed LSB-first serial frames;  |
// |            odd parity bit compiled in with macro TX_PARITY_EN.        |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module fifo_serializer_tx #(
  parameter int FIFO_WIDTH = 64,
  parameter int DIV_BITS   = 4,
  parameter int CNT_BITS   = 16
) (
  input  wire logic                clk,
  input  wire logic                reset_n,
  fifo_serializer_tx_if.slave      fifo,
  input  wire logic                tx_enable,
  input  wire logic [DIV_BITS-1:0] tx_div,
  output logic                     tx_out,
  output logic                     tx_busy,
  output logic [CNT_BITS-1:0]      words_sent
);

  localparam logic [6:0] LAST_BIT = 7'(FIFO_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
`ifdef TX_PARITY_EN
    PARITY = 3'd5,
`endif
    STOP   = 3'd4
  } state_t;

  state_t                state;
  state_t                next_state;
  logic [FIFO_WIDTH-1:0] shift_reg;
  logic [DIV_BITS-1:0]   div_q;
  logic [DIV_BITS-1:0]   div_cnt;
  logic [6:0]            bit_idx;
  logic                  bit_done;
  logic                  last_bit;
  logic                  pop;
`ifdef TX_PARITY_EN
  logic                  parity_q;
`endif

  assign bit_done = (div_cnt == div_q);
  assign last_bit = (bit_idx == LAST_BIT);
  // Gated by reset so a non-empty FIFO cannot be popped while reset is held.
  assign fifo.read_n = ~(pop & reset_n);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    tx_out     = 1'b1;
    tx_busy    = 1'b1;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        tx_busy = 1'b0;
        if (tx_enable && !fifo.fifo_empty) begin
          pop        = 1'b1;
          next_state = LOAD;
        end
      end
      LOAD: next_state = START;
      START: begin
        tx_out = 1'b0;
        if (bit_done) next_state = DATA;
      end
      DATA: begin
        tx_out = shift_reg[0];
        if (bit_done && last_bit) begin
`ifdef TX_PARITY_EN
          next_state = PARITY;
`else
          next_state = STOP;
`endif
        end
      end
`ifdef TX_PARITY_EN
      PARITY: begin
        tx_out = parity_q;
        if (bit_done) next_state = STOP;
      end
`endif
      STOP: begin
        if (bit_done) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Word, parity and divider are all captured on the pop edge and frozen for the frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_reg  <= '0;
      div_q      <= '0;
      div_cnt    <= '0;
      bit_idx    <= '0;
      words_sent <= '0;
`ifdef TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            shift_reg <= fifo.data_in;
            div_q     <= tx_div;
            div_cnt   <= '0;
            bit_idx   <= '0;
`ifdef TX_PARITY_EN
            parity_q  <= ~^fifo.data_in;
`endif
          end
        end
        LOAD: ;
        default: begin
          if (bit_done) begin
            div_cnt <= '0;
          end else begin
            div_cnt <= div_cnt + DIV_BITS'(1);
          end
          if (state == DATA && bit_done) begin
            shift_reg <= {1'b0, shift_reg[FIFO_WIDTH-1:1]};
            bit_idx   <= bit_idx + 7'd1;
          end
          if (state == STOP && bit_done) begin
            words_sent <= words_sent + CNT_BITS'(1);
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_serializer_tx.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : tb_fifo_serializer_tx                                      |
// | Purpose  : Scoreboard bench: directed words, serial-line monitor.     |
// | Revision : 1.0 - initial release                                      |
// +-----------------------------------------------------------------------+
module tb_fifo_serializer_tx;
  localparam int W  = 64;
  localparam int DB = 4;
  localparam int CB = 3;
`ifdef TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  typedef struct {
    logic [W-1:0] word;
    logic         par;
    int           div;
    int           gap;
    int           ws;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          tx_enable = 1'b0;
  logic [DB-1:0] tx_div = '0;
  logic          tx_out;
  logic          tx_busy;
  logic [CB-1:0] words_sent;

  fifo_serializer_tx_if #(.FIFO_WIDTH(W)) fif ();

  fifo_serializer_tx #(.FIFO_WIDTH(W), .DIV_BITS(DB), .CNT_BITS(CB)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .fifo       (fif),
    .tx_enable  (tx_enable),
    .tx_div     (tx_div),
    .tx_out     (tx_out),
    .tx_busy    (tx_busy),
    .words_sent (words_sent)
  );

  always #5 clk = ~clk;

  int           checks = 0;
  int           errors = 0;
  exp_t         sb[$];
  logic [W-1:0] fq[$];
  int           pops = 0;
  bit           pop_flag = 1'b0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic exp_bit(input exp_t e, input int k);
    if (k == 0) return 1'b0;
    if (k <= W) return e.word[k-1];
`ifdef TX_PARITY_EN
    if (k == W + 1) return e.par;
`endif
    return 1'b1;
  endfunction

  // FIFO model: pops on the edge after read_n was seen low, refreshes head word.
  initial begin
    fif.data_in    = '0;
    fif.fifo_empty = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (pop_flag) begin
        pop_flag = 1'b0;
        if (fq.size() > 0) void'(fq.pop_front());
        pops++;
      end
      fif.fifo_empty = (fq.size() == 0);
      fif.data_in    = (fq.size() > 0) ? fq[0] : '0;
    end
  end

  // Serial-line monitor
  bit           in_frame = 1'b0;
  bit           ws_pending = 1'b0;
  exp_t         cur;
  int           cyc, per, flen, bit_err, k;
  int           idle_cnt = 0;
  logic [W-1:0] dec;
`ifdef TX_PARITY_EN
  logic         dpar;
`endif

  always @(negedge clk) begin
    if (!reset_n) begin
      in_frame   = 1'b0;
      ws_pending = 1'b0;
      idle_cnt   = 0;
      pop_flag   = 1'b0;
    end else begin
      if (!fif.read_n) begin
        chk("pop_legal", {fif.fifo_empty, tx_busy}, '0);
        pop_flag = 1'b1;
      end
      if (ws_pending) begin
        chk("words_sent", words_sent, cur.ws[CB-1:0]);
        ws_pending = 1'b0;
      end
      if (!in_frame && tx_out == 1'b0) begin
        chk("frame_expected", sb.size() > 0, 1);
        if (sb.size() > 0) cur = sb.pop_front();
        else cur = '{word: '0, par: 1'b0, div: 0, gap: -1, ws: -1};
        if (cur.gap >= 0) chk("gap", idle_cnt, cur.gap);
        in_frame = 1'b1;
        cyc      = 0;
        per      = cur.div + 1;
        flen     = (W + 2 + P) * per;
        bit_err  = 0;
        dec      = '0;
      end
      if (in_frame) begin
        k = cyc / per;
        if (tx_out !== exp_bit(cur, k) || tx_busy !== 1'b1) bit_err++;
        if (cyc % per == 0) begin
          if (k >= 1 && k <= W) dec[k-1] = tx_out;
`ifdef TX_PARITY_EN
          if (k == W + 1) dpar = tx_out;
`endif
        end
        cyc++;
        if (cyc == flen) begin
          chk("frame_bits", bit_err, 0);
          chk("data", dec, cur.word);
`ifdef TX_PARITY_EN
          chk("parity", dpar, cur.par);
`endif
          in_frame   = 1'b0;
          ws_pending = (cur.ws >= 0);
          idle_cnt   = 0;
        end
      end else begin
        idle_cnt++;
      end
    end
  end

  task automatic push(input logic [W-1:0] w, input logic par, input int div, input int gap, input int ws);
    sb.push_back('{word: w, par: par, div: div, gap: gap, ws: ws});
    fq.push_back(w);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (!(sb.size() == 0 && !in_frame && !ws_pending && fq.size() == 0) && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({name, "_done"}, n < budget, 1);
  endtask

  task automatic wait_busy(input string name, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (tx_busy !== 1'b1 && n < budget);
    chk({name, "_busy"}, tx_busy, 1);
  endtask

  initial begin
    int bad;
    int n;
    reset_n   = 1'b0;
    tx_enable = 1'b1;
    tx_div    = 4'd0;
    repeat (3) @(negedge clk);
    chk("rst_tx_out", tx_out, 1);
    chk("rst_busy", tx_busy, 0);
    chk("rst_words", words_sent, 0);
    chk("rst_read_n", fif.read_n, 1);
    reset_n = 1'b1;

    bad = 0;
    repeat (200) begin
      @(negedge clk);
      #1;
      if (tx_out !== 1'b1 || fif.read_n !== 1'b1 || tx_busy !== 1'b0 || words_sent !== '0) bad++;
    end
    chk("idle_hold", bad, 0);

    // Single word, divider 0
    push(64'h0000_0000_0000_0001, 1'b0, 0, -1, 1);
    wait_idle("single", 400);
    chk("pops_single", pops, 1);

    // Divider 3; a divider change mid-frame must not disturb the frame
    tx_div = 4'd3;
    push(64'hA5A5_5A5A_FFFF_0000, 1'b1, 3, -1, 2);
    wait_busy("div3", 50);
    repeat (20) @(negedge clk);
    tx_div = 4'd0;
    wait_idle("div3", 1000);
    chk("pops_div3", pops, 2);

    // Three preloaded words, back to back
    tx_enable = 1'b0;
    tx_div    = 4'd1;
    push(64'h0123_4567_89AB_CDEF, 1'b1, 1, -1, 3);
    push(64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1, 2, 4);
    push(64'hDEAD_BEEF_0000_0007, 1'b0, 1, 2, 5);
    repeat (3) @(negedge clk);
    tx_enable = 1'b1;
    wait_idle("b2b", 800);
    chk("pops_b2b", pops, 5);

    // Enable dropped during the 10th data bit of the first of two queued frames
    tx_enable = 1'b0;
    tx_div    = 4'd0;
    push(64'h5555_5555_5555_5555, 1'b1, 0, -1, 6);
    push(64'hF0F0_F0F0_F0F0_F0F0, 1'b1, 0, -1, 7);
    repeat (3) @(negedge clk);
    tx_enable = 1'b1;
    wait_busy("hold", 20);
    repeat (11) @(negedge clk);
    tx_enable = 1'b0;
    n = 0;
    while (!(sb.size() == 1 && !in_frame && !ws_pending) && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("hold_frame1_done", n < 300, 1);
    repeat (50) @(negedge clk);
    chk("pops_hold", pops, 6);
    chk("fifo_left", fq.size(), 1);
    chk("words_hold", words_sent, 6);
    tx_enable = 1'b1;
    wait_idle("resume", 300);
    chk("pops_resume", pops, 7);

    // Counter wraps from 7 to 0
    push(64'h0000_0000_0000_0003, 1'b1, 0, -1, 0);
    wait_idle("wrap", 300);
    chk("pops_wrap", pops, 8);

    // Asynchronous reset during the 30th data bit
    push(64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 0, -1, -1);
    wait_busy("abort", 20);
    repeat (31) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_tx_out", tx_out, 1);
    chk("arst_busy", tx_busy, 0);
    chk("arst_words", words_sent, 0);
    chk("arst_read_n", fif.read_n, 1);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    push(64'h8000_0000_0000_0000, 1'b0, 0, -1, 1);
    wait_idle("after_rst", 300);
    chk("pops_after_rst", pops, 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
